softmax_seq_ctrl: RTL and testbench

Parametrised sequencer for the three-pass softmax datapath (max scan, normalise/exp/sum, divide/write-back). It owns the input and intermediate memory read addresses and generates every valid, clear, load and lock strobe for the datapath submodules. It processes a runtime vector length and up to NUM_CH channels back to back, and ends each job with a single `process_done` pulse. It sits between the layer scheduler (start/stall) and the softmax datapath.

---
 rtl/softmax_seq_ctrl_if.sv | 43 ++++
 rtl/softmax_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_softmax_seq_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_seq_ctrl_if.sv
// Control/strobe bundle between the layer scheduler, the softmax sequencer and the softmax datapath.
// The master modport is the sequencer's view; the slave modport is the surrounding environment.
interface softmax_seq_ctrl_if #(
    parameter int AW = 10,
    parameter int CW = 2
);
    logic          start;
    logic          stall;
    logic [AW:0]   vec_len;
    logic [CW:0]   ch_num;
    logic          busy;
    logic          process_done;
    logic          cfg_err;
    logic          rd_ena;
    logic [AW-1:0] rd_addr;
    logic          rd_src;
    logic [CW-1:0] ch_idx;
    logic          max_clr;
    logic          max_vld;
    logic          scale_load;
    logic          exp_vld;
    logic          sum_clr;
    logic          sum_lock;
    logic          im_wr_ena;
    logic [AW-1:0] im_wr_addr;
    logic          div_vld;
    logic          wb_ena;
    logic [AW-1:0] wb_addr;

    modport master (
        input  start, stall, vec_len, ch_num,
        output busy, process_done, cfg_err, rd_ena, rd_addr, rd_src, ch_idx,
               max_clr, max_vld, scale_load, exp_vld, sum_clr, sum_lock,
               im_wr_ena, im_wr_addr, div_vld, wb_ena, wb_addr
    );

    modport slave (
        output start, stall, vec_len, ch_num,
        input  busy, process_done, cfg_err, rd_ena, rd_addr, rd_src, ch_idx,
               max_clr, max_vld, scale_load, exp_vld, sum_clr, sum_lock,
               im_wr_ena, im_wr_addr, div_vld, wb_ena, wb_addr
    );
endinterface

// File: rtl/softmax_seq_ctrl.sv
// Three-pass softmax sequencer: max scan, exp/sum, divide/write-back, per channel, back to back.
// Owns the memory read addresses and every valid/clear/load/lock strobe of the datapath.
module softmax_seq_ctrl #(
    parameter int DATA_SIZE  = 1024,
    parameter int AW         = 10,
    parameter int NUM_CH     = 4,
    parameter int CW         = 2,
    parameter int RD_LAT     = 2,
    parameter int MAX_DELAY  = 2,
    parameter int NORM_DELAY = 14,
    parameter int EXP_DELAY  = 17,
    parameter int ACC_DELAY  = 9,
    parameter int DIV_DELAY  = 14
) (
    input  logic               clk,
    input  logic               rst,
    softmax_seq_ctrl_if.master bus
);
    localparam int MAX_DRN_CYC = RD_LAT + MAX_DELAY;
    localparam int EXP_DRN_CYC = RD_LAT + NORM_DELAY + EXP_DELAY + ACC_DELAY;
    localparam int DIV_DRN_CYC = RD_LAT + DIV_DELAY;
    localparam int IM_DLY      = RD_LAT + NORM_DELAY + EXP_DELAY;
    localparam int WB_DLY      = RD_LAT + DIV_DELAY;
    localparam int DRN_MAX     = (EXP_DRN_CYC > DIV_DRN_CYC)
                               ? ((EXP_DRN_CYC > MAX_DRN_CYC) ? EXP_DRN_CYC : MAX_DRN_CYC)
                               : ((DIV_DRN_CYC > MAX_DRN_CYC) ? DIV_DRN_CYC : MAX_DRN_CYC);
    localparam int DCW         = $clog2(DRN_MAX + 1);

    localparam logic [DCW-1:0] MAX_DRN_INIT = DCW'(MAX_DRN_CYC - 1);
    localparam logic [DCW-1:0] EXP_DRN_INIT = DCW'(EXP_DRN_CYC - 1);
    localparam logic [DCW-1:0] DIV_DRN_INIT = DCW'(DIV_DRN_CYC - 1);
    localparam logic [AW:0]    LEN_MAX      = (AW+1)'(DATA_SIZE);
    localparam logic [CW:0]    CH_MAX       = (CW+1)'(NUM_CH);

    typedef enum logic [3:0] {
        IDLE, MAX_RD, MAX_DRN, LOAD, EXP_RD, EXP_DRN, LOCK, DIV_RD, DIV_DRN, DONE
    } state_t;

    state_t         state;
    logic [AW:0]    len_q;
    logic [CW:0]    chn_q;
    logic [CW-1:0]  ch_idx;
    logic [AW-1:0]  rd_addr;
    logic [DCW-1:0] drn_cnt;
    logic           in_rd;
    logic           rd_src;
    logic           busy;
    logic           process_done;
    logic           cfg_err;
    logic           max_clr;
    logic           scale_load;
    logic           sum_clr;
    logic           sum_lock;

    logic           rd_ena;
    logic           last_issue;
    logic           drn_done;
    logic           cfg_ok;
    logic           more_ch;
    logic           max_issue;
    logic           exp_issue;
    logic           div_issue;

    // Issue is the only combinational output: a stall must suppress the read in the same cycle.
    assign rd_ena     = in_rd & ~bus.stall;
    assign last_issue = rd_ena && (rd_addr == AW'(len_q - (AW+1)'(1)));
    assign drn_done   = (drn_cnt == '0);
    assign cfg_ok     = (bus.vec_len != '0) && (bus.vec_len <= LEN_MAX) &&
                        (bus.ch_num != '0) && (bus.ch_num <= CH_MAX);
    assign more_ch    = (({1'b0, ch_idx} + (CW+1)'(1)) < chn_q);
    assign max_issue  = rd_ena && (state == MAX_RD);
    assign exp_issue  = rd_ena && (state == EXP_RD);
    assign div_issue  = rd_ena && (state == DIV_RD);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            len_q        <= '0;
            chn_q        <= '0;
            ch_idx       <= '0;
            rd_addr      <= '0;
            drn_cnt      <= '0;
            in_rd        <= 1'b0;
            rd_src       <= 1'b0;
            busy         <= 1'b0;
            process_done <= 1'b0;
            cfg_err      <= 1'b0;
            max_clr      <= 1'b0;
            scale_load   <= 1'b0;
            sum_clr      <= 1'b0;
            sum_lock     <= 1'b0;
        end else begin
            // NOTE: pulse strobes default low here; a later non-blocking write in the case below wins.
            cfg_err      <= 1'b0;
            process_done <= 1'b0;
            max_clr      <= 1'b0;
            scale_load   <= 1'b0;
            sum_clr      <= 1'b0;
            sum_lock     <= 1'b0;
            if (rd_ena) rd_addr <= last_issue ? '0 : rd_addr + AW'(1);
            if (!drn_done) drn_cnt <= drn_cnt - DCW'(1);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (cfg_ok) begin
                            state   <= MAX_RD;
                            len_q   <= bus.vec_len;
                            chn_q   <= bus.ch_num;
                            ch_idx  <= '0;
                            busy    <= 1'b1;
                            in_rd   <= 1'b1;
                            max_clr <= 1'b1;
                        end else begin
                            cfg_err <= 1'b1;
                        end
                    end
                end
                MAX_RD: if (last_issue) begin
                    state   <= MAX_DRN;
                    in_rd   <= 1'b0;
                    drn_cnt <= MAX_DRN_INIT;
                end
                MAX_DRN: if (drn_done) begin
                    state      <= LOAD;
                    scale_load <= 1'b1;
                    sum_clr    <= 1'b1;
                end
                LOAD: begin
                    state <= EXP_RD;
                    in_rd <= 1'b1;
                end
                EXP_RD: if (last_issue) begin
                    state   <= EXP_DRN;
                    in_rd   <= 1'b0;
                    drn_cnt <= EXP_DRN_INIT;
                end
                EXP_DRN: if (drn_done) begin
                    state    <= LOCK;
                    sum_lock <= 1'b1;
                end
                LOCK: begin
                    state  <= DIV_RD;
                    in_rd  <= 1'b1;
                    rd_src <= 1'b1;
                end
                DIV_RD: if (last_issue) begin
                    state   <= DIV_DRN;
                    in_rd   <= 1'b0;
                    rd_src  <= 1'b0;
                    drn_cnt <= DIV_DRN_INIT;
                end
                DIV_DRN: if (drn_done) begin
                    if (more_ch) begin
                        state   <= MAX_RD;
                        ch_idx  <= ch_idx + CW'(1);
                        in_rd   <= 1'b1;
                        max_clr <= 1'b1;
                    end else begin
                        state        <= DONE;
                        process_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Fixed-latency strobe pipelines; they free-run so in-flight results are tracked through stalls.
    logic [RD_LAT-1:0]          max_pipe;
    logic [RD_LAT-1:0]          exp_pipe;
    logic [RD_LAT-1:0]          div_pipe;
    logic [IM_DLY-1:0]          im_vld;
    logic [IM_DLY-1:0][AW-1:0]  im_addr;
    logic [WB_DLY-1:0]          wb_vld;
    logic [WB_DLY-1:0][AW-1:0]  wb_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            max_pipe <= '0;
            exp_pipe <= '0;
            div_pipe <= '0;
            im_vld   <= '0;
            wb_vld   <= '0;
            // NOTE: address stages are reset too, because every output must read 0 after reset.
            im_addr  <= '0;
            wb_addr  <= '0;
        end else begin
            max_pipe[0] <= max_issue;
            exp_pipe[0] <= exp_issue;
            div_pipe[0] <= div_issue;
            im_vld[0]   <= exp_issue;
            im_addr[0]  <= rd_addr;
            wb_vld[0]   <= div_issue;
            wb_addr[0]  <= rd_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                max_pipe[i] <= max_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
                div_pipe[i] <= div_pipe[i-1];
            end
            for (int i = 1; i < IM_DLY; i++) begin
                im_vld[i]  <= im_vld[i-1];
                im_addr[i] <= im_addr[i-1];
            end
            for (int i = 1; i < WB_DLY; i++) begin
                wb_vld[i]  <= wb_vld[i-1];
                wb_addr[i] <= wb_addr[i-1];
            end
        end
    end

    assign bus.busy         = busy;
    assign bus.process_done = process_done;
    assign bus.cfg_err      = cfg_err;
    assign bus.rd_ena       = rd_ena;
    assign bus.rd_addr      = rd_addr;
    assign bus.rd_src       = rd_src;
    assign bus.ch_idx       = ch_idx;
    assign bus.max_clr      = max_clr;
    assign bus.max_vld      = max_pipe[RD_LAT-1];
    assign bus.scale_load   = scale_load;
    assign bus.exp_vld      = exp_pipe[RD_LAT-1];
    assign bus.sum_clr      = sum_clr;
    assign bus.sum_lock     = sum_lock;
    assign bus.im_wr_ena    = im_vld[IM_DLY-1];
    assign bus.im_wr_addr   = im_addr[IM_DLY-1];
    assign bus.div_vld      = div_pipe[RD_LAT-1];
    assign bus.wb_ena       = wb_vld[WB_DLY-1];
    assign bus.wb_addr      = wb_addr[WB_DLY-1];
endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Bench for softmax_seq_ctrl: a schedule-level model predicts every output per cycle for each job,
// including random stall patterns, bad configurations, restarts while busy and reset mid-job.
module tb_softmax_seq_ctrl;
    localparam int DATA_SIZE  = 1024;
    localparam int AW         = 10;
    localparam int NUM_CH     = 4;
    localparam int CW         = 2;
    localparam int RD_LAT     = 2;
    localparam int MAX_DELAY  = 2;
    localparam int NORM_DELAY = 14;
    localparam int EXP_DELAY  = 17;
    localparam int ACC_DELAY  = 9;
    localparam int DIV_DELAY  = 14;
    localparam int MAX_DRN    = RD_LAT + MAX_DELAY;
    localparam int EXP_DRN    = RD_LAT + NORM_DELAY + EXP_DELAY + ACC_DELAY;
    localparam int DIV_DRN    = RD_LAT + DIV_DELAY;
    localparam int IM_DLY     = RD_LAT + NORM_DELAY + EXP_DELAY;
    localparam int WB_DLY     = RD_LAT + DIV_DELAY;
    localparam int MAXC       = 4096;

    typedef struct packed {
        logic          busy;
        logic          process_done;
        logic          cfg_err;
        logic          rd_ena;
        logic [AW-1:0] rd_addr;
        logic          rd_src;
        logic [CW-1:0] ch;
        logic          max_clr;
        logic          max_vld;
        logic          scale_load;
        logic          exp_vld;
        logic          sum_clr;
        logic          sum_lock;
        logic          im_ena;
        logic [AW-1:0] im_addr;
        logic          div_vld;
        logic          wb_ena;
        logic [AW-1:0] wb_addr;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    softmax_seq_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    softmax_seq_ctrl #(
        .DATA_SIZE(DATA_SIZE), .AW(AW), .NUM_CH(NUM_CH), .CW(CW), .RD_LAT(RD_LAT),
        .MAX_DELAY(MAX_DELAY), .NORM_DELAY(NORM_DELAY), .EXP_DELAY(EXP_DELAY),
        .ACC_DELAY(ACC_DELAY), .DIV_DELAY(DIV_DELAY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    obs_t exp_arr   [MAXC];
    logic stall_arr [MAXC];
    int   exp_end;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic obs_t sample(input bit masked);
        obs_t o;
        o              = '0;
        o.busy         = bus.busy;
        o.process_done = bus.process_done;
        o.cfg_err      = bus.cfg_err;
        o.rd_ena       = bus.rd_ena;
        o.rd_addr      = bus.rd_addr;
        o.rd_src       = bus.rd_src;
        o.ch           = bus.ch_idx;
        o.max_clr      = bus.max_clr;
        o.max_vld      = bus.max_vld;
        o.scale_load   = bus.scale_load;
        o.exp_vld      = bus.exp_vld;
        o.sum_clr      = bus.sum_clr;
        o.sum_lock     = bus.sum_lock;
        o.im_ena       = bus.im_wr_ena;
        o.im_addr      = bus.im_wr_addr;
        o.div_vld      = bus.div_vld;
        o.wb_ena       = bus.wb_ena;
        o.wb_addr      = bus.wb_addr;
        if (masked) begin
            if (!o.rd_ena) o.rd_addr = '0;
            if (!o.im_ena) o.im_addr = '0;
            if (!o.wb_ena) o.wb_addr = '0;
            if (!o.busy)   o.ch      = '0;
        end
        return o;
    endfunction

    task automatic fill_stall(input int pct);
        for (int i = 0; i < MAXC; i++) stall_arr[i] = ($urandom_range(0, 99) < pct);
    endtask

    // Reference schedule: one job starting at cycle 0, expressed as passes of L issues plus fixed gaps.
    task automatic mark(input int t, input int ch);
        exp_arr[t].busy = 1'b1;
        exp_arr[t].ch   = CW'(ch);
    endtask

    task automatic issue_pass(inout int t, input int ch, input int len, input int kind);
        int n = 0;
        while (n < len) begin
            mark(t, ch);
            if (kind == 2) exp_arr[t].rd_src = 1'b1;
            if (!stall_arr[t]) begin
                exp_arr[t].rd_ena  = 1'b1;
                exp_arr[t].rd_addr = AW'(n);
                case (kind)
                    0: exp_arr[t+RD_LAT].max_vld = 1'b1;
                    1: begin
                        exp_arr[t+RD_LAT].exp_vld = 1'b1;
                        exp_arr[t+IM_DLY].im_ena  = 1'b1;
                        exp_arr[t+IM_DLY].im_addr = AW'(n);
                    end
                    default: begin
                        exp_arr[t+RD_LAT].div_vld = 1'b1;
                        exp_arr[t+WB_DLY].wb_ena  = 1'b1;
                        exp_arr[t+WB_DLY].wb_addr = AW'(n);
                    end
                endcase
                n++;
            end
            t++;
        end
    endtask

    task automatic drain(inout int t, input int ch, input int cycles);
        for (int d = 0; d < cycles; d++) begin
            mark(t, ch);
            t++;
        end
    endtask

    task automatic build_model(input int len, input int chn);
        int t;
        for (int i = 0; i < MAXC; i++) exp_arr[i] = '0;
        if (len < 1 || len > DATA_SIZE || chn < 1 || chn > NUM_CH) begin
            exp_arr[1].cfg_err = 1'b1;
            exp_end = 1;
            return;
        end
        t = 1;
        for (int ch = 0; ch < chn; ch++) begin
            exp_arr[t].max_clr = 1'b1;
            issue_pass(t, ch, len, 0);
            drain(t, ch, MAX_DRN);
            mark(t, ch);
            exp_arr[t].scale_load = 1'b1;
            exp_arr[t].sum_clr    = 1'b1;
            t++;
            issue_pass(t, ch, len, 1);
            drain(t, ch, EXP_DRN);
            mark(t, ch);
            exp_arr[t].sum_lock = 1'b1;
            t++;
            issue_pass(t, ch, len, 2);
            drain(t, ch, DIV_DRN);
        end
        mark(t, chn - 1);
        exp_arr[t].process_done = 1'b1;
        exp_end = t;
    endtask

    // extra_start: -1 none, -2 random cycle inside the busy window; rst_cyc: -1 none.
    task automatic run_job(input string name, input int len, input int chn,
                           input int extra_start, input int rst_cyc, input int exp_done);
        int  n_cyc;
        int  done_cyc;
        int  done_cnt;
        int  max_addr;
        int  xs;
        bit  ok_cfg;
        ok_cfg = (len >= 1 && len <= DATA_SIZE && chn >= 1 && chn <= NUM_CH);
        build_model(len, chn);
        xs       = (extra_start == -2) ? int'($urandom_range(1, exp_end)) : extra_start;
        n_cyc    = (rst_cyc >= 0) ? rst_cyc + 6 : exp_end + 4;
        done_cyc = -1;
        done_cnt = 0;
        max_addr = -1;
        for (int k = 0; k < n_cyc; k++) begin
            @(posedge clk);
            #1;
            bus.start = (k == 0) || (k == xs);
            if (k == 0) begin
                bus.vec_len = (AW+1)'(len);
                bus.ch_num  = (CW+1)'(chn);
            end else begin
                bus.vec_len = (AW+1)'($urandom_range(1, DATA_SIZE));
                bus.ch_num  = (CW+1)'($urandom_range(1, NUM_CH));
            end
            bus.stall = stall_arr[k];
            rst       = (k == rst_cyc);
            @(negedge clk);
            if (rst_cyc >= 0 && k > rst_cyc)
                check($sformatf("%s@%0d post-reset", name, k), sample(1'b0), '0);
            else
                check($sformatf("%s@%0d", name, k), sample(1'b1), exp_arr[k]);
            if (bus.process_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
            if (bus.rd_ena && int'(bus.rd_addr) > max_addr) max_addr = int'(bus.rd_addr);
        end
        check({name, " done_cnt"}, done_cnt, (ok_cfg && rst_cyc < 0) ? 1 : 0);
        if (exp_done >= 0) check({name, " done_cyc"}, done_cyc, exp_done);
        if (ok_cfg && rst_cyc < 0) check({name, " last_addr"}, max_addr, len - 1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.stall   = 1'b0;
        bus.vec_len = '0;
        bus.ch_num  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", sample(1'b0), '0);
        rst = 1'b0;

        fill_stall(0);
        run_job("basic", 4, 1, -1, -1, 77);
        run_job("multi", 4, 2, -1, -1, 153);
        stall_arr[2] = 1'b1;
        stall_arr[3] = 1'b1;
        run_job("stall", 4, 1, -1, -1, 79);

        fill_stall(0);
        run_job("bad_len0", 0, 1, -1, -1, -1);
        run_job("bad_ch5", 4, NUM_CH + 1, -1, -1, -1);
        run_job("bad_len_big", DATA_SIZE + 1, 1, -1, -1, -1);
        run_job("bad_ch0", 4, 0, -1, -1, -1);
        run_job("start_busy", 4, 1, 10, -1, 77);

        fill_stall(30);
        run_job("rst_mid", 4, 1, -1, 20, -1);
        fill_stall(0);
        run_job("after_rst", 4, 1, -1, -1, 77);

        run_job("len1", 1, 1, -1, -1, 3 * 1 + 64 + 1);
        run_job("len_max", DATA_SIZE, 1, -1, -1, 3 * DATA_SIZE + 64 + 1);

        for (int i = 0; i < 12; i++) begin
            int l;
            int c;
            fill_stall(25);
            l = int'($urandom_range(1, 40));
            c = int'($urandom_range(1, NUM_CH));
            run_job($sformatf("rand%0d_L%0d_C%0d", i, l, c), l, c, -2, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
